// File: rtl/musicbox_pkg.sv
// Shared types and ROM word layout for the music box playback path.
package musicbox_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    PAUSE
  } state_t;

  // ROM word: [11:8] duration in beats, [7:0] note code
  localparam int DUR_MSB  = 11;
  localparam int DUR_LSB  = 8;
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 0;

  localparam logic [3:0] END_MARK = 4'd0;
  localparam logic [7:0] REST     = 8'd0;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Free-running beat divider: pulses tick on the terminal count while enabled.
module beat_tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int BEAT_HZ = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = CLK_HZ / BEAT_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Music box playback controller: walks the note ROM of the selected track,
// times each note in beats and handles play/pause and track selection.
module song_sequencer
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BEAT_HZ    = 16,
  parameter int GAP_CYCLES = 2000000,
  parameter int NUM_TRACKS = 4,
  parameter int ADDR_W     = 8,
  parameter int LOOP       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_pulse,
  input  logic              next_pulse,
  input  logic              prev_pulse,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [7:0]        note,
  output logic              note_on,
  output logic [3:0]        band,
  output logic              playing,
  output logic [15:0]       LED
);

  localparam int TRK_W = $clog2(NUM_TRACKS);
  localparam int OFF_W = ADDR_W - TRK_W;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic             fetch_f1_q;
  logic [TRK_W-1:0] track_q;
  logic [OFF_W-1:0] offset_q;
  logic [7:0]       note_q;
  logic             note_on_q;
  logic [3:0]       beats_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             resume_play_q;
  logic             play_pend_q;

  logic       trk_chg;
  logic       tick;
  logic       last_beat;
  logic       beat_en;
  logic       beat_clr;
  logic [3:0] rom_dur;
  logic [7:0] rom_note;

  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign trk_chg   = next_pulse ^ prev_pulse;
  assign beat_en   = (state_q == PLAY);
  // Start each note on a fresh beat boundary; resume from PAUSE keeps the count.
  assign beat_clr  = (state_q == FETCH) && fetch_f1_q && (rom_dur != END_MARK);
  assign last_beat = tick && (beats_q == 4'd1);

  beat_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BEAT_HZ(BEAT_HZ)
  ) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (beat_en),
    .clr  (beat_clr),
    .tick (tick)
  );

  // Track changes pre-empt everything else, including a same-cycle play_pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_f1_q    <= 1'b0;
      track_q       <= '0;
      offset_q      <= '0;
      note_q        <= REST;
      note_on_q     <= 1'b0;
      beats_q       <= '0;
      gap_cnt_q     <= '0;
      resume_play_q <= 1'b0;
      play_pend_q   <= 1'b0;
    end else if (trk_chg) begin
      track_q     <= next_pulse ? track_q + TRK_W'(1) : track_q - TRK_W'(1);
      offset_q    <= '0;
      note_on_q   <= 1'b0;
      play_pend_q <= 1'b0;
      fetch_f1_q  <= 1'b0;
      state_q     <= (state_q == IDLE || state_q == PAUSE) ? IDLE : FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          note_on_q <= 1'b0;
          offset_q  <= '0;
          if (play_pulse) begin
            state_q    <= FETCH;
            fetch_f1_q <= 1'b0;
          end
        end
        FETCH: begin
          if (!fetch_f1_q) begin
            fetch_f1_q <= 1'b1;
            if (play_pulse) play_pend_q <= 1'b1;
          end else begin
            fetch_f1_q <= 1'b0;
            if (rom_dur == END_MARK) begin
              offset_q <= '0;
              if (LOOP != 0) begin
                state_q     <= FETCH;
                play_pend_q <= play_pend_q | play_pulse;
              end else begin
                state_q     <= IDLE;
                play_pend_q <= 1'b0;
              end
            end else begin
              note_q      <= rom_note;
              beats_q     <= rom_dur;
              play_pend_q <= 1'b0;
              if (play_pend_q || play_pulse) begin
                state_q       <= PAUSE;
                resume_play_q <= 1'b1;
                note_on_q     <= 1'b0;
              end else begin
                state_q   <= PLAY;
                note_on_q <= (rom_note != REST);
              end
            end
          end
        end
        PLAY: begin
          if (tick) beats_q <= beats_q - 4'd1;
          if (play_pulse) begin
            state_q       <= PAUSE;
            note_on_q     <= 1'b0;
            resume_play_q <= !last_beat;
            gap_cnt_q     <= '0;
          end else if (last_beat) begin
            state_q   <= GAP;
            note_on_q <= 1'b0;
            gap_cnt_q <= '0;
          end
        end
        GAP: begin
          if (play_pulse) begin
            state_q       <= PAUSE;
            resume_play_q <= 1'b0;
          end else if (gap_cnt_q == GAP_LAST) begin
            // Running off the end of the track area acts like an end marker.
            if (offset_q == '1) begin
              offset_q <= '0;
              state_q  <= (LOOP != 0) ? FETCH : IDLE;
            end else begin
              offset_q <= offset_q + OFF_W'(1);
              state_q  <= FETCH;
            end
            fetch_f1_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        PAUSE: begin
          if (play_pulse) begin
            state_q   <= resume_play_q ? PLAY : GAP;
            note_on_q <= resume_play_q && (note_q != REST);
          end
        end
        default: begin
          state_q   <= IDLE;
          note_on_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = {track_q, offset_q};
  assign note     = note_q;
  assign note_on  = note_on_q;
  assign band     = 4'(track_q);
  assign playing  = (state_q == FETCH) || (state_q == PLAY) || (state_q == GAP);

  always_comb begin
    LED     = onehot16(4'(track_q));
    LED[14] = (state_q == PAUSE);
    LED[15] = playing;
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a tiny clock (tick every 4 cycles, 2-cycle gap).
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        playPulse;
  logic        nextPulse;
  logic        prevPulse;
  logic [7:0]  romAddr, romAddrS;
  logic [11:0] romData, romDataS;
  logic [7:0]  note, noteS;
  logic        noteOn, noteOnS;
  logic [3:0]  band, bandS;
  logic        playing, playingS;
  logic [15:0] led, ledS;

  logic [11:0] rom [0:255];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    romData  <= rom[romAddr];
    romDataS <= rom[romAddrS];
  end

  song_sequencer #(
    .CLK_HZ(16), .BEAT_HZ(4), .GAP_CYCLES(2), .NUM_TRACKS(4), .ADDR_W(8), .LOOP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play_pulse(playPulse), .next_pulse(nextPulse),
    .prev_pulse(prevPulse), .rom_addr(romAddr), .rom_data(romData), .note(note),
    .note_on(noteOn), .band(band), .playing(playing), .LED(led)
  );

  song_sequencer #(
    .CLK_HZ(16), .BEAT_HZ(4), .GAP_CYCLES(2), .NUM_TRACKS(4), .ADDR_W(8), .LOOP(0)
  ) dutStop (
    .clk(clk), .rst_n(rst_n), .play_pulse(playPulse), .next_pulse(nextPulse),
    .prev_pulse(prevPulse), .rom_addr(romAddrS), .rom_data(romDataS), .note(noteS),
    .note_on(noteOnS), .band(bandS), .playing(playingS), .LED(ledS)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulsePlay();
    playPulse = 1'b1; step(1); playPulse = 1'b0;
  endtask

  task automatic pulseNext();
    nextPulse = 1'b1; step(1); nextPulse = 1'b0;
  endtask

  task automatic pulsePrev();
    prevPulse = 1'b1; step(1); prevPulse = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; playPulse = 1'b0; nextPulse = 1'b0; prevPulse = 1'b0;
    step(2);
    compared++; if (note !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_note: got %h want 00", note); end
    compared++; if (noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_note_on: got %b want 0", noteOn); end
    compared++; if (band !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_band: got %0d want 0", band); end
    compared++; if (playing !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_playing: got %b want 0", playing); end
    compared++; if (romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_rom_addr: got %h want 00", romAddr); end
    compared++; if (led !== 16'h0001) begin mismatched++; $display("[TB] FAIL rst_led: got %h want 0001", led); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic_play();
    int highCount;
    pulsePlay();
    compared++; if (romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL f0_addr: got %h want 00", romAddr); end
    compared++; if (playing !== 1'b1) begin mismatched++; $display("[TB] FAIL f0_playing: got %b want 1", playing); end
    step(2);
    compared++; if (note !== 8'h21) begin mismatched++; $display("[TB] FAIL first_note: got %h want 21", note); end
    compared++; if (noteOn !== 1'b1) begin mismatched++; $display("[TB] FAIL first_gate: got %b want 1", noteOn); end
    highCount = 0;
    while (noteOn === 1'b1 && highCount < 20) begin highCount++; step(1); end
    compared++; if (highCount !== 8) begin mismatched++; $display("[TB] FAIL note_len: got %0d cycles want 8", highCount); end
    compared++; if (romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL gap1_addr: got %h want 00", romAddr); end
    step(1);
    compared++; if (noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL gap2_gate: got %b want 0", noteOn); end
    compared++; if (romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL gap2_addr: got %h want 00", romAddr); end
    step(1);
    compared++; if (romAddr !== 8'h01) begin mismatched++; $display("[TB] FAIL next_addr: got %h want 01", romAddr); end
  endtask

  task automatic test_rest_and_loop();
    step(2);
    compared++; if (note !== 8'h00) begin mismatched++; $display("[TB] FAIL rest_note: got %h want 00", note); end
    compared++; if (noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL rest_gate: got %b want 0", noteOn); end
    compared++; if (playing !== 1'b1) begin mismatched++; $display("[TB] FAIL rest_playing: got %b want 1", playing); end
    step(6);
    compared++; if (romAddr !== 8'h02) begin mismatched++; $display("[TB] FAIL end_addr: got %h want 02", romAddr); end
    step(2);
    compared++; if (romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL loop_addr: got %h want 00", romAddr); end
    compared++; if (playing !== 1'b1) begin mismatched++; $display("[TB] FAIL loop_playing: got %b want 1", playing); end
    compared++; if (playingS !== 1'b0) begin mismatched++; $display("[TB] FAIL stop_playing: got %b want 0", playingS); end
    compared++; if (ledS !== 16'h0001) begin mismatched++; $display("[TB] FAIL stop_led: got %h want 0001", ledS); end
    compared++; if (romAddrS !== 8'h00) begin mismatched++; $display("[TB] FAIL stop_addr: got %h want 00", romAddrS); end
    compared++; if (noteS !== 8'h00 || noteOnS !== 1'b0 || bandS !== 4'd0) begin mismatched++; $display("[TB] FAIL stop_outputs: got note %h gate %b band %0d want 00 0 0", noteS, noteOnS, bandS); end
    step(2);
    compared++; if (note !== 8'h21 || noteOn !== 1'b1) begin mismatched++; $display("[TB] FAIL replay: got note %h gate %b want 21 1", note, noteOn); end
  endtask

  task automatic test_pause();
    int highCount;
    step(2);
    compared++; if (noteOn !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_pause_gate: got %b want 1", noteOn); end
    pulsePlay();
    compared++; if (noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_gate: got %b want 0", noteOn); end
    compared++; if (led[15:14] !== 2'b01) begin mismatched++; $display("[TB] FAIL pause_led: got %b want 01", led[15:14]); end
    step(50);
    compared++; if (noteOn !== 1'b0 || romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL pause_hold: got gate %b addr %h want 0 00", noteOn, romAddr); end
    pulsePlay();
    highCount = 0;
    while (noteOn === 1'b1 && highCount < 20) begin highCount++; step(1); end
    compared++; if (highCount !== 5) begin mismatched++; $display("[TB] FAIL resume_len: got %0d cycles want 5", highCount); end
  endtask

  task automatic test_track_while_playing();
    int highCount;
    pulseNext();
    compared++; if (band !== 4'd1 || romAddr !== 8'h40) begin mismatched++; $display("[TB] FAIL play_next: got band %0d addr %h want 1 40", band, romAddr); end
    compared++; if (playing !== 1'b1 || noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL play_next_state: got playing %b gate %b want 1 0", playing, noteOn); end
    pulsePrev();
    compared++; if (band !== 4'd0 || romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL play_prev: got band %0d addr %h want 0 00", band, romAddr); end
    pulsePrev();
    compared++; if (band !== 4'd3 || romAddr !== 8'hC0) begin mismatched++; $display("[TB] FAIL play_prev_wrap: got band %0d addr %h want 3 C0", band, romAddr); end
    compared++; if (led !== 16'h8008) begin mismatched++; $display("[TB] FAIL play_led: got %h want 8008", led); end
    pulsePlay();
    compared++; if (playing !== 1'b1 || led[14] !== 1'b0) begin mismatched++; $display("[TB] FAIL pend_f1: got playing %b paused %b want 1 0", playing, led[14]); end
    step(1);
    compared++; if (led !== 16'h4008) begin mismatched++; $display("[TB] FAIL pend_pause_led: got %h want 4008", led); end
    compared++; if (note !== 8'h53 || noteOn !== 1'b0) begin mismatched++; $display("[TB] FAIL pend_note: got note %h gate %b want 53 0", note, noteOn); end
    pulsePlay();
    highCount = 0;
    while (noteOn === 1'b1 && highCount < 20) begin highCount++; step(1); end
    compared++; if (highCount !== 4) begin mismatched++; $display("[TB] FAIL pend_len: got %0d cycles want 4", highCount); end
    pulsePlay();
    compared++; if (led !== 16'h4008) begin mismatched++; $display("[TB] FAIL gap_pause_led: got %h want 4008", led); end
    pulseNext();
    compared++; if (band !== 4'd0 || playing !== 1'b0 || led !== 16'h0001) begin mismatched++; $display("[TB] FAIL pause_next: got band %0d playing %b led %h want 0 0 0001", band, playing, led); end
  endtask

  task automatic test_idle_tracks();
    logic [3:0] wantBand [0:3];
    wantBand[0] = 4'd1; wantBand[1] = 4'd2; wantBand[2] = 4'd3; wantBand[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      pulseNext();
      compared++; if (band !== wantBand[i] || playing !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_next%0d: got band %0d playing %b want %0d 0", i, band, playing, wantBand[i]); end
    end
    pulsePrev();
    compared++; if (band !== 4'd3 || led !== 16'h0008) begin mismatched++; $display("[TB] FAIL idle_prev_wrap: got band %0d led %h want 3 0008", band, led); end
  endtask

  task automatic test_simultaneous();
    nextPulse = 1'b1; prevPulse = 1'b1; step(1); nextPulse = 1'b0; prevPulse = 1'b0;
    compared++; if (band !== 4'd3 || led !== 16'h0008) begin mismatched++; $display("[TB] FAIL next_prev_both: got band %0d led %h want 3 0008", band, led); end
    nextPulse = 1'b1; playPulse = 1'b1; step(1); nextPulse = 1'b0; playPulse = 1'b0;
    compared++; if (band !== 4'd0 || playing !== 1'b0 || led !== 16'h0001) begin mismatched++; $display("[TB] FAIL next_with_play: got band %0d playing %b led %h want 0 0 0001", band, playing, led); end
    step(2);
    compared++; if (playing !== 1'b0) begin mismatched++; $display("[TB] FAIL play_dropped: got %b want 0", playing); end
  endtask

  task automatic test_reset_mid_note();
    pulseNext();
    pulsePlay();
    step(2);
    compared++; if (note !== 8'h35 || noteOn !== 1'b1 || band !== 4'd1) begin mismatched++; $display("[TB] FAIL t1_note: got note %h gate %b band %0d want 35 1 1", note, noteOn, band); end
    rst_n = 1'b0;
    step(1);
    compared++; if (noteOn !== 1'b0 || band !== 4'd0 || led !== 16'h0001) begin mismatched++; $display("[TB] FAIL mid_reset: got gate %b band %0d led %h want 0 0 0001", noteOn, band, led); end
    compared++; if (note !== 8'h00 || playing !== 1'b0 || romAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_reset_rest: got note %h playing %b addr %h want 00 0 00", note, playing, romAddr); end
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[8'h00] = 12'h221;
    rom[8'h01] = 12'h100;
    rom[8'h40] = 12'h135;
    rom[8'h80] = 12'h142;
    rom[8'hC0] = 12'h153;

    test_reset();
    test_basic_play();
    test_rest_and_loop();
    test_pause();
    test_track_while_playing();
    test_idle_tracks();
    test_simultaneous();
    test_reset_mid_note();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller for the music box. Steps through a note ROM one track at a time and times each note in beats.
- Drives note code and gate to the tone generator, and the track number (band) to the seven-segment display's data[3:0].
- Handles the play/pause, next and prev user controls. Inputs are already-debounced single-cycle pulses.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- BEAT_HZ, 16, beat tick rate. One beat is one sixteenth note.
- GAP_CYCLES, 2000000, silent articulation gap after each note, in clk cycles (>=1).
- NUM_TRACKS, 4, number of tracks (power of 2, >=2).
- ADDR_W, 8, ROM address width. Upper log2(NUM_TRACKS) bits = track, lower OFF_W bits = offset.
- LOOP, 1, 1 = restart track at end marker; 0 = stop to IDLE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- play_pulse  in  1  toggle play/pause
- next_pulse  in  1  next track
- prev_pulse  in  1  previous track
- rom_addr  out  ADDR_W  note ROM address {track, offset}
- rom_data  in  12  ROM word, 1-cycle read latency: [11:8] duration in beats, [7:0] note code
- note  out  8  current note code to the tone generator (0 = rest)
- note_on  out  1  tone gate
- band  out  4  current track number, zero-extended
- playing  out  1  high in FETCH/PLAY/GAP
- LED  out  16  status display

Behaviour:
- Reset values: state=IDLE, track=0, offset=0, note=0, note_on=0, band=0, playing=0, rom_addr=0, LED=16'h0001.
- Beat tick: counter 0..CLK_HZ/BEAT_HZ-1. Runs only in PLAY. Cleared on entry to PLAY. Tick asserted on the terminal count.
- IDLE:
  - note_on=0, offset=0.
  - play_pulse -> FETCH.
- FETCH (exactly 2 cycles):
  - F0: rom_addr={track,offset}.
  - F1: capture rom_data.
  - Duration==0 is the end marker. Set offset=0. LOOP=1 -> FETCH; LOOP=0 -> IDLE.
  - Otherwise: note=rom_data[7:0], beats=duration, note_on=(note!=0), -> PLAY.
  - note/note_on update the cycle after F1.
- PLAY:
  - Each tick decrements beats.
  - Tick with beats==1 -> GAP, note_on=0 the next cycle. Note length = duration*CLK_HZ/BEAT_HZ cycles.
- GAP:
  - GAP_CYCLES cycles with note_on=0.
  - Then offset+1 -> FETCH.
  - Offset wrap from 2^OFF_W-1 to 0 is treated as an implied end marker, following LOOP.
- PAUSE:
  - play_pulse in PLAY or GAP -> PAUSE. note_on=0, all counters frozen, resume-state bit saved.
  - play_pulse in PAUSE -> return to saved state with counters intact. note_on restored to (note!=0) if returning to PLAY.
  - play_pulse during FETCH is held pending and applied on the F1 cycle, which then goes to PAUSE with resume=PLAY.
- next_pulse: track=(track+1) mod NUM_TRACKS.
- prev_pulse: track=(track-1) mod NUM_TRACKS.
- Track change (next or prev), in all cases:
  - offset=0, note_on=0.
  - From FETCH/PLAY/GAP -> FETCH of the new track. From IDLE/PAUSE -> IDLE.
  - band follows track the next cycle.
- Simultaneous events:
  - next and prev in the same cycle: both ignored.
  - Track change together with play_pulse: track change wins, play_pulse dropped.
- LED:
  - [NUM_TRACKS-1:0] = one-hot track.
  - [14] = paused.
  - [15] = playing.
  - Others 0.
- Reset asserted mid-note: all outputs return to reset values on the next edge. No residual tone.

Decomposition:
- musicbox_pkg:
  - state enum {IDLE, FETCH, PLAY, GAP, PAUSE}
  - ROM field positions DUR_MSB/DUR_LSB/NOTE_MSB/NOTE_LSB
  - END_MARK=4'd0, REST=8'd0
- Sub-module beat_tick_gen (CLK_HZ, BEAT_HZ):
  - inputs: clk, rst_n, en, clr
  - output: tick

Test Plan (CLK_HZ=16, BEAT_HZ=4 → tick every 4 cycles, GAP_CYCLES=2; ROM track0 = {2,0x21},{1,0x00},{0,x}):
- Reset, play_pulse → rom_addr=0x00; note=0x21, note_on=1 two cycles later, held 8 cycles; then 2 cycles note_on=0; rom_addr=0x01.
- Rest entry 0x00, duration 1 → note_on=0 for 4 cycles. End marker with LOOP=1 → rom_addr returns to 0x00, note 0x21 replays. With LOOP=0 → IDLE, playing=0.
- play_pulse 3 cycles into note 0x21 → note_on=0, LED[14]=1. Wait 50 cycles, then play_pulse → note_on=1 for the remaining 5 cycles only.
- next_pulse three times from track 0 → band 1,2,3; a fourth → band 0. prev_pulse at track 0 → band 3. Same pulses while playing → rom_addr={new_track,0}.
- next_pulse and prev_pulse in the same cycle → band unchanged. next_pulse with play_pulse in IDLE → band+1, stays IDLE.
- rst_n=0 for 1 cycle during PLAY → note_on=0, band=0, LED=16'h0001 the next cycle.
